reg_bank_wb: RTL and testbench
==============================

Name: reg_bank_wb

Overview:
- 32x32-bit MIPS general-purpose register bank for the multicycle datapath.
- Sits directly downstream of the write-register-address mux. That mux's 5-bit result drives wr_addr; the write-data mux drives wr_data.
- Read ports feed the A/B operand registers.
- Includes a debug dump sequencer that streams all 32 registers over a valid/ready port, used for end-of-test state checks.

Parameters:
- WIDTH, 32, register data width.
- SP_INIT, 32'd227, reset value of register 29 ($sp).
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data (write-through); 0 = returns the stored value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr_a  in  5  read port A address (instruction [25..21]).
- rd_addr_b  in  5  read port B address (instruction [20..16]).
- rd_data_a  out  WIDTH  read port A data, combinational.
- rd_data_b  out  WIDTH  read port B data, combinational.
- wr_en  in  1  register write enable (RegWrite).
- wr_addr  in  5  write address, from the write-register mux.
- wr_data  in  WIDTH  write data.
- dbg_start  in  1  one-cycle pulse starting a dump.
- dbg_valid  out  1  dump beat valid.
- dbg_ready  in  1  sink accepts the beat.
- dbg_addr  out  5  register index of the current beat.
- dbg_data  out  WIDTH  register contents of the current beat.
- dbg_busy  out  1  high while a dump is in progress.

Behaviour:
- Reset (reset low, asynchronous assert):
  - all registers = 0, except reg 29 = SP_INIT;
  - FSM goes to IDLE; dbg_valid = 0, dbg_busy = 0, dbg_addr = 0, dbg_data = 0.
  - Release is sampled on clk.
- Register 0:
  - reads always return 0;
  - writes to address 0 are discarded;
  - the bypass never applies to address 0.
- Write:
  - on the rising edge with wr_en = 1 and wr_addr != 0, reg[wr_addr] <= wr_data.
  - Latency 1 cycle: the value is visible on reads the following cycle.
- Read:
  - purely combinational from the address inputs.
  - If BYPASS = 1, wr_en = 1, wr_addr == rd_addr_x and rd_addr_x != 0, then rd_data_x = wr_data in the same cycle.
  - Ports A and B resolve independently; both may hit the bypass at once.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: on dbg_start -> SEND, with idx = 0 and dbg_busy = 1.
  - SEND:
    - dbg_valid = 1, dbg_addr = idx, dbg_data = reg[idx], read live (not bypassed).
    - On dbg_valid && dbg_ready, idx increments.
    - If idx == 31 at acceptance -> DONE.
    - When dbg_ready = 0, dbg_addr and dbg_data hold stable, except that a datapath write to reg[idx] updates dbg_data. The sink samples at acceptance.
  - DONE: one cycle with dbg_valid = 0 and dbg_busy still 1, then -> IDLE with dbg_busy = 0.
- dbg_start is ignored outside IDLE; there is no restart mid-dump.
- The idx counter is 5 bits. Wrap from 31 to 0 is never observed, because DONE is entered first.
- A datapath write during a dump is permitted. The beat reflects the register contents at the acceptance edge, before that edge's write.
- Reset mid-dump aborts immediately to IDLE, with all debug outputs zero.

Decomposition:
- Shared MIPS package holds:
  - REG_SP = 5'd29, REG_RA = 5'd31, REG_ZERO = 5'd0;
  - the dump FSM state encoding (2 bits);
  - the SP_INIT default.
  - The write-register mux should use the same REG_SP/REG_RA constants.
- One sub-module: reg_dump_seq, containing the FSM, idx counter and handshake. It drives a 5-bit read address into a third internal read port of the bank.
- The storage array and read muxes stay in the top.

Test Plan:
- Reset check: pulse reset low mid-cycle, read all 32 addresses -> reg 29 = 227, all others = 0; dbg_valid = 0.
- Write then read: write 0xDEADBEEF to reg 8 -> next cycle rd_data_a (addr 8) = 0xDEADBEEF.
  - Write 0x1234 to reg 0 -> rd_data_b (addr 0) = 0.
- Bypass, with BYPASS = 1: same cycle wr_en = 1, wr_addr = 31, wr_data = 0x400, rd_addr_a = 31 -> rd_data_a = 0x400 that cycle.
  - With BYPASS = 0, the old value is returned and 0x400 appears the next cycle.
- Dual port: write reg 5 = 7 and reg 6 = 9, read A = 5 and B = 6 -> 7 and 9 simultaneously.
- Dump with backpressure: preload reg n = n*3, dbg_start, dbg_ready toggling 1-0-1 -> 32 accepted beats in order 0..31 with data n*3 (reg 0 = 0, reg 29 = 87); one DONE cycle; dbg_busy falls after it.
- Reset mid-dump: assert reset after beat 10 accepted -> dbg_busy = 0 and dbg_valid = 0 immediately; reg 29 = 227; a new dbg_start restarts from idx 0.

Source files
------------

// File: rtl/reg_bank_wb_pkg.sv
// Shared MIPS datapath constants: architectural register indices, the reset
// value of $sp and the state encoding of the register-dump sequencer.
package reg_bank_wb_pkg;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [4:0]  REG_RA   = 5'd31;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'd227;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump_seq.sv
// Debug dump sequencer: walks register indices 0..31 over a valid/ready port,
// reading the bank through a dedicated unbypassed read port.
module reg_dump_seq
  import reg_bank_wb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ready,
  input  logic [WIDTH-1:0] rd_data,
  output logic [4:0]       rd_addr,
  output logic             valid,
  output logic [4:0]       addr,
  output logic [WIDTH-1:0] data,
  output logic             busy
);

  dump_state_t state, state_next;
  logic [4:0]  idx, idx_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DUMP_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    valid      = 1'b0;
    busy       = 1'b0;
    unique case (state)
      DUMP_IDLE: begin
        if (start) begin
          state_next = DUMP_SEND;
          idx_next   = '0;
        end
      end
      DUMP_SEND: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          idx_next = idx + 5'd1;
          if (idx == REG_RA) state_next = DUMP_DONE;
        end
      end
      DUMP_DONE: begin
        busy       = 1'b1;
        state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  // Beat data is a live read, so a write to reg[idx] while stalled shows up.
  assign rd_addr = idx;
  assign addr    = valid ? idx : '0;
  assign data    = valid ? rd_data : '0;

endmodule

// File: rtl/reg_bank_wb.sv
// 32x32 MIPS general-purpose register bank with two combinational read ports,
// optional write-through bypass and a debug dump port.
module reg_bank_wb
  import reg_bank_wb_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEFAULT),
  parameter bit               BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             dbg_start,
  output logic             dbg_valid,
  input  logic             dbg_ready,
  output logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             dbg_busy
);

  logic [WIDTH-1:0] regs [32];
  logic [4:0]       dump_addr;
  logic [WIDTH-1:0] dump_data;
  logic             wr_live;

  assign wr_live = wr_en && (wr_addr != REG_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i[4:0]] <= (i[4:0] == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : regs[rd_addr_a];
    if (BYPASS && wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : regs[rd_addr_b];
    if (BYPASS && wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end

  // Dump port sees stored contents only; reg 0 is never written so it reads 0.
  assign dump_data = regs[dump_addr];

  reg_dump_seq #(
    .WIDTH(WIDTH)
  ) u_dump (
    .clk    (clk),
    .reset  (reset),
    .start  (dbg_start),
    .ready  (dbg_ready),
    .rd_data(dump_data),
    .rd_addr(dump_addr),
    .valid  (dbg_valid),
    .addr   (dbg_addr),
    .data   (dbg_data),
    .busy   (dbg_busy)
  );

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: one bypassing and one non-bypassing
// instance share all inputs.
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic        wr_en, dbg_start, dbg_ready;
  logic [31:0] wr_data;

  logic [31:0] rd_data_a, rd_data_b, dbg_data;
  logic        dbg_valid, dbg_busy;
  logic [4:0]  dbg_addr;

  logic [31:0] nb_rd_data_a, nb_rd_data_b, nb_dbg_data;
  logic        nb_dbg_valid, nb_dbg_busy;
  logic [4:0]  nb_dbg_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank_wb #(.WIDTH(32), .SP_INIT(32'd227), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_start(dbg_start), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy)
  );

  reg_bank_wb #(.WIDTH(32), .SP_INIT(32'd227), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_start(dbg_start), .dbg_valid(nb_dbg_valid), .dbg_ready(dbg_ready),
    .dbg_addr(nb_dbg_addr), .dbg_data(nb_dbg_data), .dbg_busy(nb_dbg_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    write_reg(5'd3, 32'hCAFE_0003);
    #2 reset = 1'b0;
    #1;
    total++;
    if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0 || dbg_addr !== 5'd0 || dbg_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_dbg: valid=%b busy=%b addr=%0d data=%h, want 0 0 0 0",
               dbg_valid, dbg_busy, dbg_addr, dbg_data);
    end
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      exp = (i == 29) ? 32'd227 : 32'd0;
      total++;
      if (rd_data_a !== exp) begin
        bad++;
        $display("FAIL reset_reg_a[%0d]: got %h want %h", i, rd_data_a, exp);
      end
      exp = ((31 - i) == 29) ? 32'd227 : 32'd0;
      total++;
      if (rd_data_b !== exp) begin
        bad++;
        $display("FAIL reset_reg_b[%0d]: got %h want %h", 31 - i, rd_data_b, exp);
      end
    end
  endtask

  task automatic test_write_read;
    rd_addr_a = 5'd8;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if (nb_rd_data_a !== 32'd0) begin
      bad++;
      $display("FAIL wr_latency_pre: got %h want 00000000", nb_rd_data_a);
    end
    tick();
    wr_en = 1'b0;
    #1;
    total++;
    if (rd_data_a !== 32'hDEAD_BEEF || nb_rd_data_a !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL wr_read_8: got %h/%h want deadbeef", rd_data_a, nb_rd_data_a);
    end
    rd_addr_b = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    #1;
    total++;
    if (rd_data_b !== 32'd0) begin
      bad++;
      $display("FAIL r0_no_bypass: got %h want 00000000", rd_data_b);
    end
    tick();
    wr_en = 1'b0;
    #1;
    total++;
    if (rd_data_b !== 32'd0 || nb_rd_data_b !== 32'd0) begin
      bad++;
      $display("FAIL r0_discard: got %h/%h want 00000000", rd_data_b, nb_rd_data_b);
    end
  endtask

  task automatic test_bypass;
    rd_addr_a = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h400;
    #1;
    total++;
    if (rd_data_a !== 32'h400) begin
      bad++;
      $display("FAIL bypass_on: got %h want 00000400", rd_data_a);
    end
    total++;
    if (nb_rd_data_a !== 32'd0) begin
      bad++;
      $display("FAIL bypass_off_old: got %h want 00000000", nb_rd_data_a);
    end
    tick();
    wr_en = 1'b0;
    #1;
    total++;
    if (nb_rd_data_a !== 32'h400) begin
      bad++;
      $display("FAIL bypass_off_next: got %h want 00000400", nb_rd_data_a);
    end
    rd_addr_a = 5'd12; rd_addr_b = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
    #1;
    total++;
    if (rd_data_a !== 32'h55 || rd_data_b !== 32'h55) begin
      bad++;
      $display("FAIL bypass_both: got %h/%h want 00000055", rd_data_a, rd_data_b);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_dual_port;
    write_reg(5'd5, 32'd7);
    write_reg(5'd6, 32'd9);
    rd_addr_a = 5'd5; rd_addr_b = 5'd6;
    #1;
    total++;
    if (rd_data_a !== 32'd7 || rd_data_b !== 32'd9 || nb_rd_data_a !== 32'd7 || nb_rd_data_b !== 32'd9) begin
      bad++;
      $display("FAIL dual_port: got %0d,%0d/%0d,%0d want 7,9", rd_data_a, rd_data_b,
               nb_rd_data_a, nb_rd_data_b);
    end
  endtask

  task automatic test_dump_backpressure;
    int beats = 0;
    int cyc   = 0;
    logic r   = 1'b1;
    for (int n = 1; n < 32; n++) write_reg(5'(n), 32'(n * 3));
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    while (beats < 32 && cyc < 200) begin
      dbg_ready = r;
      #1;
      total++;
      if (dbg_valid !== 1'b1 || dbg_busy !== 1'b1 || dbg_addr !== 5'(beats)) begin
        bad++;
        $display("FAIL dump_beat_ctrl: valid=%b busy=%b addr=%0d want 1 1 %0d",
                 dbg_valid, dbg_busy, dbg_addr, beats);
      end
      if (r) begin
        total++;
        if (dbg_data !== 32'(beats * 3)) begin
          bad++;
          $display("FAIL dump_beat_data[%0d]: got %0d want %0d", beats, dbg_data, beats * 3);
        end
        beats++;
      end
      r = ~r;
      tick();
      cyc++;
    end
    dbg_ready = 1'b0;
    total++;
    if (beats != 32) begin
      bad++;
      $display("FAIL dump_beat_count: got %0d want 32", beats);
    end
    #1;
    total++;
    if (dbg_valid !== 1'b0 || dbg_busy !== 1'b1) begin
      bad++;
      $display("FAIL dump_done_cycle: valid=%b busy=%b want 0 1", dbg_valid, dbg_busy);
    end
    tick();
    total++;
    if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0) begin
      bad++;
      $display("FAIL dump_idle_after: valid=%b busy=%b want 0 0", dbg_valid, dbg_busy);
    end
  endtask

  task automatic test_reset_mid_dump;
    int beats = 0;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    dbg_ready = 1'b1;
    while (beats < 11) begin
      tick();
      beats++;
    end
    #1;
    reset = 1'b0;
    rd_addr_a = 5'd29; rd_addr_b = 5'd8;
    #1;
    total++;
    if (dbg_busy !== 1'b0 || dbg_valid !== 1'b0 || dbg_addr !== 5'd0 || dbg_data !== 32'd0) begin
      bad++;
      $display("FAIL midreset_dbg: valid=%b busy=%b addr=%0d data=%h want 0 0 0 0",
               dbg_valid, dbg_busy, dbg_addr, dbg_data);
    end
    total++;
    if (rd_data_a !== 32'd227 || rd_data_b !== 32'd0) begin
      bad++;
      $display("FAIL midreset_regs: sp=%0d r8=%0d want 227 0", rd_data_a, rd_data_b);
    end
    tick();
    reset = 1'b1;
    dbg_ready = 1'b0;
    tick();
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    total++;
    if (dbg_valid !== 1'b1 || dbg_addr !== 5'd0 || dbg_data !== 32'd0) begin
      bad++;
      $display("FAIL restart_idx0: valid=%b addr=%0d data=%h want 1 0 0", dbg_valid, dbg_addr, dbg_data);
    end
    dbg_ready = 1'b1;
    tick();
    total++;
    if (dbg_addr !== 5'd1 || dbg_data !== 32'd0) begin
      bad++;
      $display("FAIL restart_idx1: addr=%0d data=%h want 1 0", dbg_addr, dbg_data);
    end
  endtask

  initial begin
    reset = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    dbg_start = 1'b0; dbg_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_port();
    test_dump_backpressure();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
